// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat
// events plus a held level; one instance per button.
module button_event_gen #(
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned COUNTER_BITS  = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic repeat_en_i,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam logic [COUNTER_BITS-1:0] LONG_LAST   = COUNTER_BITS'(LONG_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] REPEAT_LAST = COUNTER_BITS'(REPEAT_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_ONE     = COUNTER_BITS'(1);

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_e;

    state_e                  state_q;
    logic [COUNTER_BITS-1:0] cnt_q;
    logic                    press_q;
    logic                    release_q;
    logic                    click_q;
    logic                    long_press_q;
    logic                    repeat_q;
    logic                    held_q;

    // Counter is shared by the hold and repeat phases and cleared on every state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOCKOUT;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            click_q      <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            click_q      <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            held_q       <= 1'b0;
            case (state_q)
                LOCKOUT: begin
                    if (!btn_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                IDLE: begin
                    if (btn_i) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        click_q   <= 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q      <= LONG;
                        cnt_q        <= '0;
                        long_press_q <= 1'b1;
                        held_q       <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        held_q <= 1'b1;
                    end
                end
                LONG: begin
                    // Release wins over any repeat match on the same edge.
                    if (!btn_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                    end else begin
                        held_q <= 1'b1;
                        if (!repeat_en_i) begin
                            cnt_q <= '0;
                        end else if (cnt_q == REPEAT_LAST) begin
                            cnt_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= LOCKOUT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign click_o      = click_q;
    assign long_press_o = long_press_q;
    assign repeat_o     = repeat_q;
    assign held_o       = held_q;

endmodule
